// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the shift-register sequencing controller:
//   - mode codes driven on {ch1,ch0} to the mux-selected flip-flop cells
//   - controller state encoding
// ---------------------------------------------------------------------------
package ctrl_pkg;

    localparam logic [1:0] MODO_HOLD   = 2'b00;
    localparam logic [1:0] MODO_DESLOC = 2'b01;
    localparam logic [1:0] MODO_CARGA  = 2'b10;
    localparam logic [1:0] MODO_RESERV = 2'b11;  // cells hold; never driven

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } estado_t;

endpackage

// File: rtl/registrador_desloc.sv
// ---------------------------------------------------------------------------
// registrador_desloc
// WIDTH-bit universal register slice controlled by a 2-bit mode select.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset, clears the register
//   i_modo  : {ch1,ch0}; 00 hold, 01 shift right (0 fill), 10 load, 11 hold
//   i_dado  : parallel load word
//   o_q     : register contents
// ---------------------------------------------------------------------------
module registrador_desloc
    import ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_modo,
    input  logic [WIDTH-1:0] i_dado,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            case (i_modo)
                // a logical shift keeps WIDTH=1 legal (no reversed slice)
                MODO_DESLOC: r_q <= r_q >> 1;
                MODO_CARGA:  r_q <= i_dado;
                default:     r_q <= r_q;    // hold, and reserved code
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/controle_deslocamento.sv
// ---------------------------------------------------------------------------
// controle_deslocamento
// Sequencing controller: accepts a parallel word on a start/ready handshake,
// loads it into the register slice and shifts it out serially, LSB first.
// The same {ch1,ch0} mode select is exported so external slices can follow.
//
// Ports:
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   start       : transfer request, sampled only while ready=1
//   dado_in     : parallel word, captured on the accepting edge
//   ready       : idle, start accepted this cycle
//   busy        : transfer in progress
//   serial_out  : current serial bit
//   bit_valid   : serial_out carries a data or parity bit
//   done        : one-cycle pulse after the last bit
//   ch1, ch0    : mode select to the register cells
//   reg_q       : internal register contents
//
// Build option: define CTRL_PARIDADE_EN to append an even-parity bit after
// the data bits (one extra PARITY cycle before DONE).
// ---------------------------------------------------------------------------
module controle_deslocamento
    import ctrl_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dado_in,
    output logic             ready,
    output logic             busy,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             done,
    output logic             ch1,
    output logic             ch0,
    output logic [WIDTH-1:0] reg_q
);

    estado_t          r_estado;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       w_modo;
    logic [WIDTH-1:0] w_q;
`ifdef CTRL_PARIDADE_EN
    logic             r_paridade;
`endif

    registrador_desloc #(.WIDTH(WIDTH)) u_reg (
        .clk    (clk),
        .rst    (rst),
        .i_modo (w_modo),
        .i_dado (dado_in),
        .o_q    (w_q)
    );

    // Controller state and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado   <= IDLE;
            r_cnt      <= '0;
`ifdef CTRL_PARIDADE_EN
            r_paridade <= 1'b0;
`endif
        end else begin
            case (r_estado)
                IDLE: begin
                    if (start) begin
                        r_cnt    <= '0;
                        r_estado <= SHIFT;
`ifdef CTRL_PARIDADE_EN
                        // even parity: makes the total count of ones even
                        r_paridade <= ^dado_in;
`endif
                    end
                end
                SHIFT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
`ifdef CTRL_PARIDADE_EN
                        r_estado <= PARITY;
`else
                        r_estado <= DONE;
`endif
                    end
                end
`ifdef CTRL_PARIDADE_EN
                PARITY:  r_estado <= DONE;
`endif
                DONE:    r_estado <= IDLE;
                default: r_estado <= IDLE;
            endcase
        end
    end

    // Output decode: combinational from state, start and register contents.
    // The load mode is asserted in IDLE together with start so the register
    // captures dado_in on the very edge that accepts the request.
    always_comb begin
        ready      = 1'b0;
        busy       = 1'b0;
        serial_out = 1'b0;
        bit_valid  = 1'b0;
        done       = 1'b0;
        w_modo     = MODO_HOLD;
        case (r_estado)
            IDLE: begin
                ready  = 1'b1;
                w_modo = start ? MODO_CARGA : MODO_HOLD;
            end
            SHIFT: begin
                busy       = 1'b1;
                bit_valid  = 1'b1;
                serial_out = w_q[0];
                w_modo     = MODO_DESLOC;
            end
`ifdef CTRL_PARIDADE_EN
            PARITY: begin
                busy       = 1'b1;
                bit_valid  = 1'b1;
                serial_out = r_paridade;
            end
`endif
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign ch1   = w_modo[1];
    assign ch0   = w_modo[0];
    assign reg_q = w_q;

endmodule

// File: tb/tb_controle_deslocamento.sv
// ---------------------------------------------------------------------------
// tb_controle_deslocamento
// Bench for controle_deslocamento. The reference model expands every
// accepted word into the list of per-cycle outputs it must produce
// (data bits, optional parity bit, done) and replays that list cycle by
// cycle; an empty list means the controller must be idle.
// ---------------------------------------------------------------------------
module tb_controle_deslocamento;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dado_in;
    logic             ready;
    logic             busy;
    logic             serial_out;
    logic             bit_valid;
    logic             done;
    logic             ch1;
    logic             ch0;
    logic [WIDTH-1:0] reg_q;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic             sout;
        logic             bval;
        logic             dn;
        logic [1:0]       ch;
        logic [WIDTH-1:0] regq;
    } rec_t;

    rec_t exp_q[$];

    controle_deslocamento #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dado_in    (dado_in),
        .ready      (ready),
        .busy       (busy),
        .serial_out (serial_out),
        .bit_valid  (bit_valid),
        .done       (done),
        .ch1        (ch1),
        .ch0        (ch0),
        .reg_q      (reg_q)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expand one accepted word into the cycles that follow the accept edge.
    task automatic enfileira(input logic [WIDTH-1:0] word);
        rec_t r;
        for (int k = 0; k < WIDTH; k++) begin
            r.sout = word[k];
            r.bval = 1'b1;
            r.dn   = 1'b0;
            r.ch   = 2'b01;
            r.regq = word >> k;
            exp_q.push_back(r);
        end
`ifdef CTRL_PARIDADE_EN
        r.sout = 1'(($countones(word) % 2));
        r.bval = 1'b1;
        r.dn   = 1'b0;
        r.ch   = 2'b00;
        r.regq = '0;
        exp_q.push_back(r);
`endif
        r.sout = 1'b0;
        r.bval = 1'b0;
        r.dn   = 1'b1;
        r.ch   = 2'b00;
        r.regq = '0;
        exp_q.push_back(r);
    endtask

    task automatic confere_reset();
        verifica("rst_ready", ready, 1);
        verifica("rst_busy", busy, 0);
        verifica("rst_done", done, 0);
        verifica("rst_bval", bit_valid, 0);
        verifica("rst_sout", serial_out, 0);
        verifica("rst_ch", {ch1, ch0}, 0);
        verifica("rst_regq", reg_q, 0);
    endtask

    // One clock cycle: drive inputs after the falling edge, optionally pulse
    // rst with no clock edge, then compare outputs against the model.
    task automatic ciclo(input logic s, input logic [WIDTH-1:0] d, input bit aborta);
        rec_t r;
        @(negedge clk);
        start   = aborta ? 1'b0 : s;
        dado_in = d;
        if (aborta) begin
            #1 rst = 1'b1;
            #1 confere_reset();
            rst = 1'b0;
            exp_q.delete();
        end
        #1;
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            verifica("ready", ready, 0);
            verifica("busy", busy, 1);
            verifica("sout", serial_out, r.sout);
            verifica("bval", bit_valid, r.bval);
            verifica("done", done, r.dn);
            verifica("ch", {ch1, ch0}, r.ch);
            verifica("regq", reg_q, r.regq);
        end else begin
            verifica("idle_ready", ready, 1);
            verifica("idle_busy", busy, 0);
            verifica("idle_sout", serial_out, 0);
            verifica("idle_bval", bit_valid, 0);
            verifica("idle_done", done, 0);
            verifica("idle_ch", {ch1, ch0}, start ? 2'b10 : 2'b00);
            verifica("idle_regq", reg_q, 0);
            if (start) enfileira(dado_in);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        dado_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset pulse without a clock edge
        ciclo(1'b0, '0, 1'b1);

        // basic transfer of 1011
        ciclo(1'b1, 4'b1011, 1'b0);
        repeat (7) ciclo(1'b0, 4'b0000, 1'b0);

        // start with 4'hF while busy must be ignored
        ciclo(1'b1, 4'b1011, 1'b0);
        repeat (4) ciclo(1'b1, 4'hF, 1'b0);
        repeat (4) ciclo(1'b0, 4'h0, 1'b0);

        // start held high: back-to-back transfers of 0001
        repeat (30) ciclo(1'b1, 4'b0001, 1'b0);
        repeat (8) ciclo(1'b0, 4'h0, 1'b0);

        // abort during the second bit, then a normal transfer
        ciclo(1'b1, 4'b1011, 1'b0);
        ciclo(1'b0, 4'h0, 1'b0);
        ciclo(1'b0, 4'h0, 1'b1);
        repeat (3) ciclo(1'b0, 4'h0, 1'b0);
        ciclo(1'b1, 4'b0110, 1'b0);
        repeat (8) ciclo(1'b0, 4'h0, 1'b0);

        // randomized traffic with occasional aborts
        for (int i = 0; i < 800; i++) begin
            ciclo(($urandom_range(0, 2) == 0), WIDTH'($urandom),
                  ($urandom_range(0, 59) == 0));
        end
        repeat (8) ciclo(1'b0, 4'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
